load_use_scoreboard: RTL

- Producer-side companion to the execute-stage forwarding logic in the dual-issue pipeline.
- It records in-flight register writes whose results are not yet forwardable: loads and multi-cycle ALU ops.
- It asserts decode-stage stalls for each issue lane until every such result has reached a stage that forwarding covers.
- It sits between decode/issue, which allocates entries, and the hazard/stall controller, which consumes the stall outputs.

---
 rtl/load_use_scoreboard_pkg.sv | 18 +
 rtl/load_use_scoreboard_free_picker.sv | 32 +++
 rtl/load_use_scoreboard.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/load_use_scoreboard_pkg.sv
// Shared sizing, latency constants and the tracking-entry layout for the
// load-use scoreboard.
package load_use_scoreboard_pkg;

    localparam int DEPTH_DEF = 4;
    localparam int CNT_W_DEF = 3;
    localparam int REG_W_DEF = 5;

    localparam int LAT_LOAD = 1;
    localparam int LAT_MUL  = 3;

    typedef struct packed {
        logic                 valid;
        logic [REG_W_DEF-1:0] dest;
        logic [CNT_W_DEF-1:0] cnt;
    } sb_entry_t;

endpackage

// File: rtl/load_use_scoreboard_free_picker.sv
// Priority encoder over the free-entry mask: reports the lowest and the
// second-lowest free slot together with their found flags.
module sb_free_picker #(
    parameter  int DEPTH = 4,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0] free,
    output logic [IDX_W-1:0] first_idx,
    output logic             first_found,
    output logic [IDX_W-1:0] second_idx,
    output logic             second_found
);

    always_comb begin
        first_idx    = '0;
        first_found  = 1'b0;
        second_idx   = '0;
        second_found = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (free[i]) begin
                if (!first_found) begin
                    first_found = 1'b1;
                    first_idx   = IDX_W'(i);
                end else if (!second_found) begin
                    second_found = 1'b1;
                    second_idx   = IDX_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/load_use_scoreboard.sv
// Tracks in-flight long-latency register writes (loads, multi-cycle ALU ops)
// and stalls each decode lane until those results become forwardable.
module load_use_scoreboard
    import load_use_scoreboard_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int REG_W = REG_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             alloc0_valid,
    input  logic [REG_W-1:0] alloc0_dest,
    input  logic [CNT_W-1:0] alloc0_lat,
    input  logic             alloc1_valid,
    input  logic [REG_W-1:0] alloc1_dest,
    input  logic [CNT_W-1:0] alloc1_lat,
    input  logic [REG_W-1:0] rs0D,
    input  logic [REG_W-1:0] rt0D,
    input  logic [REG_W-1:0] rs1D,
    input  logic [REG_W-1:0] rt1D,
    input  logic             pipe_hold,
    input  logic             flush,
    output logic             stall0,
    output logic             stall1,
    output logic             alloc_ready,
    output logic [CNT_W-1:0] pending_cnt,
    output logic             overflow_err
);

    localparam int IDX_W = $clog2(DEPTH);

    sb_entry_t entries_q [DEPTH];

    logic [DEPTH-1:0] free;
    logic [IDX_W-1:0] first_idx;
    logic [IDX_W-1:0] second_idx;
    logic             first_found;
    logic             second_found;

    logic             req0;
    logic             req1;
    logic             grant0;
    logic             grant1;
    logic [IDX_W-1:0] slot1;
    logic             drop;

    // Free state is taken from the registered table, before this cycle's aging.
    always_comb begin
        free = '0;
        for (int i = 0; i < DEPTH; i++) begin
            free[i] = !entries_q[i].valid;
        end
    end

    sb_free_picker #(
        .DEPTH (DEPTH)
    ) u_picker (
        .free         (free),
        .first_idx    (first_idx),
        .first_found  (first_found),
        .second_idx   (second_idx),
        .second_found (second_found)
    );

    always_comb begin
        req0   = alloc0_valid && (alloc0_dest != '0) && (alloc0_lat != '0) && !pipe_hold && !flush;
        req1   = alloc1_valid && (alloc1_dest != '0) && (alloc1_lat != '0) && !pipe_hold && !flush;
        grant0 = req0 && first_found;
        // Lane1 takes the slot after lane0's when both allocate together.
        grant1 = req1 && (req0 ? second_found : first_found);
        slot1  = req0 ? second_idx : first_idx;
        drop   = (req0 && !grant0) || (req1 && !grant1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            overflow_err <= 1'b0;
        end else begin
            if (flush) begin
                for (int i = 0; i < DEPTH; i++) begin
                    entries_q[i].valid <= 1'b0;
                end
            end else if (!pipe_hold) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (entries_q[i].valid) begin
                        entries_q[i].cnt <= entries_q[i].cnt - CNT_W_DEF'(1);
                        if (entries_q[i].cnt == CNT_W_DEF'(1)) begin
                            entries_q[i].valid <= 1'b0;
                        end
                    end
                end
                // Allocation only targets free slots, so it never collides with aging.
                if (grant0) begin
                    entries_q[first_idx] <= '{valid: 1'b1, dest: alloc0_dest, cnt: alloc0_lat};
                end
                if (grant1) begin
                    entries_q[slot1] <= '{valid: 1'b1, dest: alloc1_dest, cnt: alloc1_lat};
                end
            end
            if (drop) begin
                overflow_err <= 1'b1;
            end
        end
    end

    logic hit_rs0;
    logic hit_rt0;
    logic hit_rs1;
    logic hit_rt1;

    // Stalls look only at registered entries; register zero never hazards.
    always_comb begin
        hit_rs0 = 1'b0;
        hit_rt0 = 1'b0;
        hit_rs1 = 1'b0;
        hit_rt1 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entries_q[i].valid) begin
                if (entries_q[i].dest == rs0D) hit_rs0 = 1'b1;
                if (entries_q[i].dest == rt0D) hit_rt0 = 1'b1;
                if (entries_q[i].dest == rs1D) hit_rs1 = 1'b1;
                if (entries_q[i].dest == rt1D) hit_rt1 = 1'b1;
            end
        end
        stall0 = (hit_rs0 && (rs0D != '0)) || (hit_rt0 && (rt0D != '0));
        stall1 = stall0 || (hit_rs1 && (rs1D != '0)) || (hit_rt1 && (rt1D != '0));
    end

    always_comb begin
        pending_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            pending_cnt = pending_cnt + CNT_W'(entries_q[i].valid);
        end
        alloc_ready = (DEPTH - int'(pending_cnt)) >= 2;
    end

endmodule
